// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the instruction ROM read port between fetch (IF) and load/debug (LS)
module imem_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              if_rready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rerr,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  input  logic              ls_rready,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_rerr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [CNT_W-1:0]  if_gnt_cnt,
  output logic [CNT_W-1:0]  ls_gnt_cnt
);
  logic fl_v, fl_own, fl_err, hd_v, hd_own, hd_err, last_gnt;
  logic [DATA_W-1:0] hd_data;
  logic [ADDR_W-1:0] addr_q;
  logic r_v, r_own, r_err, r_rdy, stall;
  logic [DATA_W-1:0] r_data;
  // owner 0 = IF, 1 = LS; the hold register always takes priority over the in-flight word
  always_comb begin
    r_own = hd_v ? hd_own : fl_own;
    r_err = hd_v ? hd_err : fl_err;
    r_v = (hd_v || fl_v) && !(!r_own && if_flush);
    r_data = r_err ? '0 : hd_v ? hd_data : rom_data;
    r_rdy = r_own ? ls_rready : if_rready;
    stall = r_v && !r_rdy;
    if_gnt = !rst && !stall && if_req && (!ls_req || last_gnt);
    ls_gnt = !rst && !stall && ls_req && (!if_req || !last_gnt);
    rom_addr = if_gnt ? if_addr : ls_gnt ? ls_addr : addr_q;
    if_rvalid = r_v && !r_own;
    ls_rvalid = r_v && r_own;
    if_rerr = if_rvalid && r_err;
    ls_rerr = ls_rvalid && r_err;
    if_rdata = if_rvalid ? r_data : '0;
    ls_rdata = ls_rvalid ? r_data : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fl_v <= 1'b0;
      fl_own <= 1'b0;
      fl_err <= 1'b0;
      hd_v <= 1'b0;
      hd_own <= 1'b0;
      hd_err <= 1'b0;
      hd_data <= '0;
      last_gnt <= 1'b1;
      addr_q <= '0;
      if_gnt_cnt <= '0;
      ls_gnt_cnt <= '0;
    end else begin
      fl_v <= if_gnt || ls_gnt;
      fl_own <= ls_gnt;
      fl_err <= |rom_addr[1:0];
      addr_q <= rom_addr;
      if (if_gnt || ls_gnt) last_gnt <= ls_gnt;
      // a stall can only begin on an in-flight word, since no grant is issued while one is pending
      hd_v <= stall;
      if (stall && !hd_v) begin
        hd_own <= fl_own;
        hd_err <= fl_err;
        hd_data <= r_data;
      end
      if (if_gnt && !(&if_gnt_cnt)) if_gnt_cnt <= if_gnt_cnt + 1'b1;
      if (ls_gnt && !(&ls_gnt_cnt)) ls_gnt_cnt <= ls_gnt_cnt + 1'b1;
    end
  end
endmodule
